hash_fold: RTL and testbench
============================

Name: hash_fold

Overview:
- Parametrised, multi-cycle folding hash engine; successor to the fixed 64-bit/10-bit fold hash.
- Splits a KEY_W-bit key into HASH_W-bit segments and folds them into a HASH_W-bit index.
  - ADD mode: end-around-carry sum.
  - XOR mode: XOR fold.
- Segments are processed SEG_PER_CYC per cycle; a per-request seed is supported.
- Sits between the key extractor and the table lookup stage; same start/ready handshake as the existing hash.

Parameters:
- KEY_W, 64: key width in bits.
- HASH_W, 10: hash width; result is always < 2^HASH_W.
- DATA_W, 32: width of hash_val_o; result is zero-extended. Must be >= HASH_W.
- SEG_PER_CYC, 2: segments folded per FOLD cycle, 1..NSEG.
- Derived:
  - NSEG = ceil(KEY_W/HASH_W).
  - NFOLD = ceil(NSEG/SEG_PER_CYC).
  - ACC_W = HASH_W + clog2(NSEG+2).

Ports:
- clk, input, 1: clock; all state changes on rising edge.
- rst, input, 1: asynchronous, active-low reset (0 = reset).
- start_i, input, 1: request; level-sensitive, sampled in FREE.
- key_i, input, KEY_W: key; latched on accept.
- mode_i, input, 1: 0 = ADD, 1 = XOR; latched on accept.
- seed_i, input, HASH_W: initial accumulator value; latched on accept.
- busy_o, output, 1: high in FOLD/REDUCE.
- hash_ready_o, output, 1: result valid.
- hash_val_o, output, DATA_W: result, zero-extended.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = FREE; accumulator, index, latched key/mode = 0.
  - busy_o = 0, hash_ready_o = 0, hash_val_o = 0.
  - Reset asserted mid-operation aborts immediately; no result is produced.
- Segmentation:
  - Segment i = key[i*HASH_W +: HASH_W], for i = 0..NSEG-1.
  - The top segment is zero-padded above bit KEY_W-1.
- FREE:
  - On start_i=1: latch key, mode, seed; acc <= zero-extended seed; idx <= 0; hash_ready_o <= 0; busy_o <= 1; go to FOLD.
  - Otherwise hold all outputs (a previous result stays visible with hash_ready_o=1).
- FOLD, one cycle per group:
  - Combine segments idx..min(idx+SEG_PER_CYC, NSEG)-1 into acc. ADD: acc + sum (ACC_W bits, no overflow possible). XOR: acc ^ xor-of-segments.
  - idx += SEG_PER_CYC.
  - After the last group:
    - ADD: go to REDUCE.
    - XOR: hash_val_o <= result; hash_ready_o <= 1; busy_o <= 0; go to DONE.
  - start_i and key_i are ignored during FOLD and REDUCE.
- REDUCE (ADD only):
  - If acc[ACC_W-1:HASH_W] != 0: acc <= acc[HASH_W-1:0] + acc[ACC_W-1:HASH_W]; stay in REDUCE.
  - Else: hash_val_o <= {0, acc[HASH_W-1:0]}; hash_ready_o <= 1; busy_o <= 0; go to DONE.
  - Terminates within clog2(ACC_W)+1 iterations.
- DONE:
  - Hold hash_val_o and hash_ready_o.
  - Return to FREE only when start_i=0. A held start_i therefore yields exactly one hash.
- Latency, counted in edges after the accept edge:
  - XOR: NFOLD.
  - ADD: NFOLD + 1 + number of non-trivial reductions.
- Default state encoding: any illegal state goes to FREE.

Test Plan:
- Reset behaviour: rst=0 applied -> busy_o=0, hash_ready_o=0, hash_val_o=0. Release, start_i=0 for 5 cycles -> outputs unchanged.
- Defaults, ADD, key=0x0000_0000_0000_0401, seed=0 -> busy_o high edges 0..4; hash_ready_o=1 after edge 5; hash_val_o=0x002.
- Same key in XOR mode -> hash_ready_o=1 after edge 4; hash_val_o=0x000.
- Defaults, ADD, key=0xFFFF_FFFF_FFFF_FFFF, seed=0:
  - Fold gives 6153; one reduction gives 15.
  - Expect hash_ready_o=1 after edge 6, hash_val_o=0x00F.
  - Repeat with seed=0x3F0, XOR mode -> hash_val_o=0x3FF after edge 4.
- start_i held high for 20 cycles with key changing every cycle -> exactly one result, computed from the key at the accept edge; FSM stays in DONE until start_i=0; next start clears hash_ready_o on accept.
- Parametric variants:
  - KEY_W=32, HASH_W=8, SEG_PER_CYC=4, ADD, key=0xFFFF_FFFF -> hash_val_o=0x0FF after edge 3.
  - rst pulsed low at edge 2 of a request -> no hash_ready_o; outputs at reset values.

Source files
------------

// File: rtl/hash_fold.sv
// Multi-cycle folding hash: splits a key into HASH_W-bit segments and folds them
// into a HASH_W-bit index by end-around-carry addition or XOR, with a per-request seed.
module hash_fold #(
    parameter int unsigned KEY_W       = 64,
    parameter int unsigned HASH_W      = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SEG_PER_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic              mode_i,
    input  logic [HASH_W-1:0] seed_i,
    output logic              busy_o,
    output logic              hash_ready_o,
    output logic [DATA_W-1:0] hash_val_o
);

    localparam int unsigned NSEG  = (KEY_W + HASH_W - 1) / HASH_W;
    localparam int unsigned NFOLD = (NSEG + SEG_PER_CYC - 1) / SEG_PER_CYC;
    localparam int unsigned ACC_W = HASH_W + $clog2(NSEG + 2);
    localparam int unsigned PAD_W = NSEG * HASH_W;
    localparam int unsigned HI_W  = ACC_W - HASH_W;
    localparam int unsigned IDX_W = $clog2(NFOLD * SEG_PER_CYC + 1);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_FOLD   = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              mode_q, mode_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] val_q, val_d;

    logic [PAD_W-1:0]  key_pad;
    logic [ACC_W-1:0]  seg_sum;
    logic [HASH_W-1:0] seg_xor;
    logic [ACC_W-1:0]  acc_fold;
    logic [HI_W-1:0]   acc_hi;
    logic              last_group;

    // Combine the segments of the current group [idx, idx+SEG_PER_CYC) clipped to NSEG
    always_comb begin
        key_pad = PAD_W'(key_q);
        seg_sum = '0;
        seg_xor = '0;
        for (int unsigned i = 0; i < NSEG; i++) begin
            if (i >= 32'(idx_q) && i < 32'(idx_q) + SEG_PER_CYC) begin
                seg_sum = seg_sum + ACC_W'(key_pad[i*HASH_W +: HASH_W]);
                seg_xor = seg_xor ^ key_pad[i*HASH_W +: HASH_W];
            end
        end
        last_group = (32'(idx_q) + SEG_PER_CYC >= NSEG);
        acc_fold   = mode_q ? (acc_q ^ ACC_W'(seg_xor)) : (acc_q + seg_sum);
        acc_hi     = acc_q[ACC_W-1:HASH_W];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        val_d   = val_q;
        case (state_q)
            S_FREE: begin
                if (start_i) begin
                    key_d   = key_i;
                    mode_d  = mode_i;
                    acc_d   = ACC_W'(seed_i);
                    idx_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                acc_d = acc_fold;
                idx_d = idx_q + IDX_W'(SEG_PER_CYC);
                if (last_group) begin
                    if (mode_q) begin
                        val_d   = DATA_W'(acc_fold[HASH_W-1:0]);
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REDUCE;
                    end
                end
            end
            S_REDUCE: begin
                // End-around carry: fold overflow bits back into the low word
                if (acc_hi != '0) begin
                    acc_d = ACC_W'(acc_q[HASH_W-1:0]) + ACC_W'(acc_hi);
                end else begin
                    val_d   = DATA_W'(acc_q[HASH_W-1:0]);
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!start_i) begin
                    state_d = S_FREE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FREE;
            key_q   <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            val_q   <= val_d;
        end
    end

    assign busy_o       = busy_q;
    assign hash_ready_o = ready_q;
    assign hash_val_o   = val_q;

endmodule

// File: tb/tb_hash_fold.sv
// Directed bench for hash_fold: default 64/10/2 instance plus a 32/8/4 variant.
module tb_hash_fold;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [63:0] key;
    logic        mode;
    logic [9:0]  seed;
    logic        busy;
    logic        ready;
    logic [31:0] val;

    logic        start8;
    logic [31:0] key8;
    logic        mode8;
    logic [7:0]  seed8;
    logic        busy8;
    logic        ready8;
    logic [31:0] val8;

    int checks = 0;
    int errors = 0;

    hash_fold dut (
        .clk(clk), .rst(rst), .start_i(start), .key_i(key), .mode_i(mode),
        .seed_i(seed), .busy_o(busy), .hash_ready_o(ready), .hash_val_o(val)
    );

    hash_fold #(.KEY_W(32), .HASH_W(8), .DATA_W(32), .SEG_PER_CYC(4)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .key_i(key8), .mode_i(mode8),
        .seed_i(seed8), .busy_o(busy8), .hash_ready_o(ready8), .hash_val_o(val8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle one edge (DONE -> FREE), then present a request accepted on the next edge (edge 0)
    task automatic launch(input logic [63:0] k, input logic m, input logic [9:0] s);
        tick();
        key   = k;
        mode  = m;
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; key = '0; mode = 1'b0; seed = '0;
        start8 = 1'b0; key8 = '0; mode8 = 1'b0; seed8 = '0;
        #3;
        checks++;
        if ({busy, ready, val} !== 34'h0) begin
            errors++;
            $display("FAIL reset_state: busy/ready/val got %b/%b/%h exp 0/0/0", busy, ready, val);
        end
        checks++;
        if ({busy8, ready8, val8} !== 34'h0) begin
            errors++;
            $display("FAIL reset_state8: busy/ready/val got %b/%b/%h exp 0/0/0", busy8, ready8, val8);
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({busy, ready, val} !== 34'h0) begin
                errors++;
                $display("FAIL reset_idle c%0d: busy/ready/val got %b/%b/%h exp 0/0/0", c, busy, ready, val);
            end
        end
    endtask

    task automatic test_add_small();
        launch(64'h0000_0000_0000_0401, 1'b0, 10'h0);
        for (int e = 0; e <= 5; e++) begin
            if (e > 0) tick();
            checks++;
            if (e < 5) begin
                if ({busy, ready} !== 2'b10) begin
                    errors++;
                    $display("FAIL add_small e%0d: busy/ready got %b/%b exp 1/0", e, busy, ready);
                end
            end else if ({busy, ready, val} !== {2'b01, 32'h002}) begin
                errors++;
                $display("FAIL add_small e%0d: busy/ready/val got %b/%b/%h exp 0/1/002", e, busy, ready, val);
            end
        end
    endtask

    task automatic test_xor_small();
        launch(64'h0000_0000_0000_0401, 1'b1, 10'h0);
        for (int e = 0; e <= 4; e++) begin
            if (e > 0) tick();
            checks++;
            if (e < 4) begin
                if ({busy, ready} !== 2'b10) begin
                    errors++;
                    $display("FAIL xor_small e%0d: busy/ready got %b/%b exp 1/0", e, busy, ready);
                end
            end else if ({busy, ready, val} !== {2'b01, 32'h000}) begin
                errors++;
                $display("FAIL xor_small e%0d: busy/ready/val got %b/%b/%h exp 0/1/000", e, busy, ready, val);
            end
        end
    endtask

    task automatic test_add_ones();
        launch(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10'h0);
        for (int e = 0; e <= 6; e++) begin
            if (e > 0) tick();
            checks++;
            if (e < 6) begin
                if ({busy, ready} !== 2'b10) begin
                    errors++;
                    $display("FAIL add_ones e%0d: busy/ready got %b/%b exp 1/0", e, busy, ready);
                end
            end else if ({busy, ready, val} !== {2'b01, 32'h00F}) begin
                errors++;
                $display("FAIL add_ones e%0d: busy/ready/val got %b/%b/%h exp 0/1/00f", e, busy, ready, val);
            end
        end
    endtask

    task automatic test_xor_seed();
        launch(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 10'h3F0);
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (e < 4) begin
                if (ready !== 1'b0) begin
                    errors++;
                    $display("FAIL xor_seed e%0d: ready got %b exp 0", e, ready);
                end
            end else if ({busy, ready, val} !== {2'b01, 32'h3FF}) begin
                errors++;
                $display("FAIL xor_seed e%0d: busy/ready/val got %b/%b/%h exp 0/1/3ff", e, busy, ready, val);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   accepts;
        int   rises;
        logic pb;
        logic pr;
        tick();
        key = 64'hFFFF_FFFF_FFFF_FFFF; mode = 1'b0; seed = 10'h0; start = 1'b1;
        accepts = 0; rises = 0; pb = busy; pr = ready;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (busy && !pb) accepts++;
            if (ready && !pr) rises++;
            pb  = busy;
            pr  = ready;
            key = {32'(32'hDEAD_0000 + c), 32'(c * 7 + 3)};
        end
        checks++;
        if (accepts !== 1) begin
            errors++;
            $display("FAIL held_accepts: got %0d exp 1", accepts);
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL held_results: got %0d exp 1", rises);
        end
        checks++;
        if ({busy, ready, val} !== {2'b01, 32'h00F}) begin
            errors++;
            $display("FAIL held_value: busy/ready/val got %b/%b/%h exp 0/1/00f", busy, ready, val);
        end
        start = 1'b0;
        tick();
        checks++;
        if ({busy, ready, val} !== {2'b01, 32'h00F}) begin
            errors++;
            $display("FAIL held_release: busy/ready/val got %b/%b/%h exp 0/1/00f", busy, ready, val);
        end
        key = 64'h0000_0000_0000_0401; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, ready} !== 2'b10) begin
            errors++;
            $display("FAIL restart_accept: busy/ready got %b/%b exp 1/0", busy, ready);
        end
        for (int e = 1; e <= 4; e++) tick();
        checks++;
        if ({busy, ready, val} !== {2'b01, 32'h000}) begin
            errors++;
            $display("FAIL restart_result: busy/ready/val got %b/%b/%h exp 0/1/000", busy, ready, val);
        end
    endtask

    task automatic test_variant8();
        tick();
        key8 = 32'hFFFF_FFFF; mode8 = 1'b0; seed8 = 8'h0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (e < 3) begin
                if ({busy8, ready8} !== 2'b10) begin
                    errors++;
                    $display("FAIL variant8 e%0d: busy/ready got %b/%b exp 1/0", e, busy8, ready8);
                end
            end else if ({busy8, ready8, val8} !== {2'b01, 32'h0FF}) begin
                errors++;
                $display("FAIL variant8 e%0d: busy/ready/val got %b/%b/%h exp 0/1/0ff", e, busy8, ready8, val8);
            end
        end
    endtask

    task automatic test_reset_abort();
        launch(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 10'h3F0);
        for (int e = 1; e <= 4; e++) tick();
        checks++;
        if ({ready, val} !== {1'b1, 32'h3FF}) begin
            errors++;
            $display("FAIL abort_pre: ready/val got %b/%h exp 1/3ff", ready, val);
        end
        launch(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10'h0);
        checks++;
        if ({busy, ready, val} !== {2'b10, 32'h3FF}) begin
            errors++;
            $display("FAIL abort_accept: busy/ready/val got %b/%b/%h exp 1/0/3ff", busy, ready, val);
        end
        tick();
        @(posedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, ready, val} !== 34'h0) begin
            errors++;
            $display("FAIL abort_reset: busy/ready/val got %b/%b/%h exp 0/0/0", busy, ready, val);
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if ({busy, ready, val} !== 34'h0) begin
                errors++;
                $display("FAIL abort_after c%0d: busy/ready/val got %b/%b/%h exp 0/0/0", c, busy, ready, val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_small();
        test_xor_small();
        test_add_ones();
        test_xor_seed();
        test_back_to_back();
        test_variant8();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
